sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: SDRAM word address width.
REQ-002 Parameter TIMEOUT, default 1023: maximum number of REQ-state cycles allowed before abort.
REQ-003 sys_clk  in  1  system clock; single clock domain.
REQ-004 sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 a_req, a_we  in  1 each  port A (MCU) request level; 1 = write, 0 = read.
REQ-006 a_addr  in  ADDR_W  port A word address.
REQ-007 a_wdata  in  16  port A write data.
REQ-008 a_ack, a_err  out  1 each  port A completion pulse and timeout pulse.
REQ-009 a_rdata  out  16  port A read data.
REQ-010 b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: port B (loader/DMA) signals, identical in direction and width to port A.
REQ-011 mem_wr_req, mem_rd_req  out  1 each  request levels to the SDRAM controller.
REQ-012 mem_addr  out  ADDR_W; mem_wdata  out  16: command address and write data.
REQ-013 mem_wr_ack, mem_rd_ack  in  1 each; mem_rdata  in  16: controller responses.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 grant  out  1  port owning the current transaction; 0 = A, 1 = B.

Function
REQ-016 The arbiter SHALL use a three-state FSM: IDLE, REQ, DONE.
REQ-017 IDLE: if any req is sampled high, the arbiter SHALL latch the winning port's we, addr and wdata into internal registers, set grant, and go to REQ.
REQ-018 Arbitration SHALL be round-robin:
  - A sole requester wins.
  - If both request, the port not served last wins.
  - The "last served" register SHALL update on every DONE, including timeouts.
REQ-019 REQ: the arbiter SHALL drive exactly one of mem_wr_req or mem_rd_req high (selected by the latched we), hold it high every REQ cycle, and drive mem_addr and mem_wdata from the latched registers.
REQ-020 In REQ, the arbiter SHALL act on the matching ack only. A mem_rd_ack during a write, or a mem_wr_ack during a read, SHALL be ignored.
REQ-021 When the matching ack is sampled high in REQ, the arbiter SHALL:
  - go to DONE on the next edge, with mem_*_req low from that edge;
  - for a read, capture mem_rdata on that same edge.
REQ-022 A REQ-cycle counter SHALL clear on entry to REQ. If it reaches TIMEOUT without a matching ack, the arbiter SHALL deassert mem_*_req and go to DONE with an error flag set.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE. In DONE, the arbiter SHALL drive the granted port's ack high, or its err high if the error flag is set. It SHALL never drive both, and SHALL drive neither on the other port.
REQ-024 x_rdata SHALL update only on a successful read to port x and SHALL hold its value otherwise, including across writes and timeouts.
REQ-025 Requester rule: req SHALL be held until ack/err. Dropping req during REQ SHALL NOT abort the transaction.
REQ-026 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-027 Latency: from the edge sampling req in IDLE, mem_*_req SHALL be high after 1 edge. ack SHALL be high 1 cycle after the edge sampling the controller ack. The minimum is 2 cycles from req sample to ack high.
REQ-028 Changes to a_*/b_* inputs while busy SHALL NOT affect mem_addr or mem_wdata.

Reset
REQ-029 While sys_rst_n is low, asynchronously:
  - state = IDLE;
  - all outputs = 0;
  - latched registers, counter and error flag = 0;
  - "last served" = B, so A wins the first contention.
REQ-030 Reset asserted mid-transaction SHALL drop mem_*_req immediately and generate no ack or err.

Verification
REQ-031 A read only, addr=0x000123, controller acks 3 cycles after mem_rd_req rises with mem_rdata=0xBEEF -> one a_ack pulse, a_rdata=0xBEEF, b_ack=0, busy falls after DONE.
REQ-032 a_req and b_req rise in the same cycle, both writes, req held high continuously -> grant sequence A, B, A, B, with mem_wr_req never high for both ports at once.
REQ-033 B write pending, mem_wr_ack tied 0, TIMEOUT=1023 -> mem_wr_req drops after 1023 REQ cycles, b_err pulses once, b_ack=0, b_rdata unchanged.
REQ-034 A read in REQ, controller pulses mem_wr_ack -> ignored, transaction continues until mem_rd_ack.
REQ-035 sys_rst_n pulsed low during REQ -> mem_rd_req=0 at once, no ack, FSM in IDLE, next contention won by A.
REQ-036 a_addr changed during REQ -> mem_addr holds the latched value until DONE.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller.
// One transaction in flight at a time: IDLE -> REQ -> DONE, with a timeout abort in REQ.
module sdram_arbiter #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    // Port A (MCU)
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [15:0]       a_rdata,
    // Port B (loader/DMA)
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [15:0]       b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [15:0]       b_rdata,
    // SDRAM controller side
    output logic              mem_wr_req,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_wr_ack,
    input  logic              mem_rd_ack,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              grant
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e              r_state;
    logic                r_grant;
    logic                r_last;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic                r_wr_req;
    logic                r_rd_req;
    logic [15:0]         r_a_rdata;
    logic [15:0]         r_b_rdata;

    logic                w_win;
    logic                w_sel_we;
    logic                w_match;
    logic                w_cnt_last;
    logic                w_done;

    // Contention goes to the port not served last; a sole requester always wins.
    always_comb begin
        w_win      = (a_req && b_req) ? ~r_last : b_req;
        w_sel_we   = w_win ? b_we : a_we;
        w_match    = r_we ? mem_wr_ack : mem_rd_ack;
        w_cnt_last = (r_cnt == CNT_LAST);
        w_done     = (r_state == StDone);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= StIdle;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_wr_req  <= 1'b0;
            r_rd_req  <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (a_req || b_req) begin
                        r_grant  <= w_win;
                        r_we     <= w_sel_we;
                        r_addr   <= w_win ? b_addr : a_addr;
                        r_wdata  <= w_win ? b_wdata : a_wdata;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        r_wr_req <= w_sel_we;
                        r_rd_req <= ~w_sel_we;
                        r_state  <= StReq;
                    end
                end
                StReq: begin
                    // Only the ack matching the latched direction is honoured.
                    if (w_match) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_state  <= StDone;
                        if (!r_we) begin
                            if (r_grant) begin
                                r_b_rdata <= mem_rdata;
                            end else begin
                                r_a_rdata <= mem_rdata;
                            end
                        end
                    end else if (w_cnt_last) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_last  <= r_grant;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Completion pulses are decoded from registered state only, so they last exactly DONE.
    assign a_ack      = w_done && !r_err && !r_grant;
    assign a_err      = w_done &&  r_err && !r_grant;
    assign b_ack      = w_done && !r_err &&  r_grant;
    assign b_err      = w_done &&  r_err &&  r_grant;
    assign a_rdata    = r_a_rdata;
    assign b_rdata    = r_b_rdata;
    assign mem_wr_req = r_wr_req;
    assign mem_rd_req = r_rd_req;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign busy       = (r_state != StIdle);
    assign grant      = r_grant;

endmodule
